// File: rtl/pos_pkt_arbiter.sv
// pos_pkt_arbiter: merges NUM_CELLS position-cache packet streams into one
// output. Each cell has a small FIFO (no back-pressure to the caches), and a
// one-entry output register is refilled from a non-empty FIFO chosen by
// round-robin arbitration.
// Build option: define POS_ARB_FIXED_PRIO_EN to make the lowest-index
// non-empty FIFO always win. Ports and timing are the same in both builds.
`ifndef OFFSET_PKT_STRUCT_WIDTH
`define OFFSET_PKT_STRUCT_WIDTH 32
`endif

module pos_pkt_arbiter #(
  parameter int NUM_CELLS  = 8,
  parameter int PKT_WIDTH  = `OFFSET_PKT_STRUCT_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CELLS-1:0][PKT_WIDTH-1:0]  i_pos_pkt,
  input  logic [NUM_CELLS-1:0]                 i_valid,
  input  logic                                 i_flush,
  output logic [PKT_WIDTH-1:0]                 o_pkt,
  output logic [$clog2(NUM_CELLS)-1:0]         o_cell_id,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [NUM_CELLS-1:0]                 o_almost_full,
  output logic [NUM_CELLS-1:0]                 o_overflow,
  output logic                                 o_idle
);

  localparam int ID_W  = $clog2(NUM_CELLS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PKT_WIDTH-1:0]                mem_q [NUM_CELLS][FIFO_DEPTH];
  logic [NUM_CELLS-1:0][PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [NUM_CELLS-1:0][PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NUM_CELLS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [PKT_WIDTH-1:0]                pkt_q, pkt_d;
  logic [ID_W-1:0]                     id_q, id_d;
  logic [ID_W-1:0]                     last_q, last_d;
  logic                                valid_q, valid_d;
  logic [NUM_CELLS-1:0]                ovf_q, ovf_d;
  logic                                armed_q, armed_d;

  logic [NUM_CELLS-1:0]                nonempty, full, push, pop;
  logic                                load, found;
  logic [ID_W-1:0]                     grant;

  // Per-cell occupancy status derived from the counters
  always_comb begin
    for (int unsigned c = 0; c < NUM_CELLS; c++) begin
      nonempty[c]      = (cnt_q[c] != '0);
      full[c]          = (cnt_q[c] == CNT_W'(FIFO_DEPTH));
      o_almost_full[c] = (cnt_q[c] >= CNT_W'(FIFO_DEPTH - 1));
    end
  end

  // Arbitration: first non-empty FIFO from the search start
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
`ifdef POS_ARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = (32'(last_q) + 1 + i) % NUM_CELLS;
`endif
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  // Next-state: FIFO bookkeeping, output register and sticky overflow
  always_comb begin
    load     = !valid_q || i_ready;
    pop      = '0;
    push     = '0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    pkt_d    = pkt_q;
    id_d     = id_q;
    last_d   = last_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    armed_d  = 1'b1;

    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      last_d   = '0;
    end else begin
      if (load) begin
        if (found) begin
          pop[grant] = 1'b1;
          pkt_d      = mem_q[grant][rd_ptr_q[grant]];
          id_d       = grant;
          last_d     = grant;
          valid_d    = 1'b1;
        end else begin
          valid_d    = 1'b0;
        end
      end
      // A full FIFO still accepts a push when it is popped in the same cycle
      for (int unsigned c = 0; c < NUM_CELLS; c++) begin
        push[c] = armed_q && i_valid[c] && (!full[c] || pop[c]);
        if (armed_q && i_valid[c] && full[c] && !pop[c])
          ovf_d[c] = 1'b1;
        if (push[c])
          wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(1);
        if (pop[c])
          rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
        cnt_d[c] = cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
      end
    end
  end

  // Packet storage; push is already suppressed during flush
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CELLS; c++) begin
      if (push[c])
        mem_q[c][wr_ptr_q[c]] <= i_pos_pkt[c];
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      pkt_q    <= '0;
      id_q     <= '0;
      last_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= '0;
      armed_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      id_q     <= id_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      armed_q  <= armed_d;
    end
  end

  assign o_pkt      = pkt_q;
  assign o_cell_id  = id_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;
  assign o_idle     = !valid_q && !(|nonempty);

endmodule

// File: tb/tb_pos_pkt_arbiter.sv
// Bench for pos_pkt_arbiter: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pos_pkt_arbiter;

  localparam int N = 8;
  localparam int D = 4;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0][W-1:0] pkt_in = '0;
  logic [N-1:0]        vin = '0;
  logic                flush = 1'b0;
  logic                ready = 1'b0;
  logic [W-1:0]        o_pkt;
  logic [2:0]          o_cell_id;
  logic                o_valid;
  logic [N-1:0]        o_almost_full;
  logic [N-1:0]        o_overflow;
  logic                o_idle;

  int n_checks = 0;
  int n_fail   = 0;

  pos_pkt_arbiter #(.NUM_CELLS(N), .PKT_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .i_pos_pkt(pkt_in), .i_valid(vin), .i_flush(flush),
    .o_pkt(o_pkt), .o_cell_id(o_cell_id), .o_valid(o_valid), .i_ready(ready),
    .o_almost_full(o_almost_full), .o_overflow(o_overflow), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-cell queues and a one-entry output slot
  logic [W-1:0] mq [N][$];
  logic [W-1:0] m_pkt   = '0;
  int           m_id    = 0;
  int           m_last  = 0;
  bit           m_valid = 1'b0;
  bit [N-1:0]   m_ovf   = '0;
  bit           m_armed = 1'b0;

  always @(posedge clk or negedge rst) begin
    int p;
    int c;
    if (!rst) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      m_valid = 1'b0; m_pkt = '0; m_id = 0; m_last = 0; m_ovf = '0; m_armed = 1'b0;
    end else begin
      if (flush) begin
        for (int k = 0; k < N; k++) mq[k].delete();
        m_valid = 1'b0;
        m_last  = 0;
      end else begin
        p = -1;
        if (!m_valid || ready) begin
          for (int i = 1; i <= N; i++) begin
`ifdef POS_ARB_FIXED_PRIO_EN
            c = i - 1;
`else
            c = (m_last + i) % N;
`endif
            if (p < 0 && mq[c].size() > 0) p = c;
          end
          if (p >= 0) begin
            m_pkt   = mq[p].pop_front();
            m_id    = p;
            m_last  = p;
            m_valid = 1'b1;
          end else begin
            m_valid = 1'b0;
          end
        end
        if (m_armed) begin
          for (int k = 0; k < N; k++) begin
            if (vin[k]) begin
              if (mq[k].size() < D) mq[k].push_back(pkt_in[k]);
              else m_ovf[k] = 1'b1;
            end
          end
        end
      end
      m_armed = 1'b1;
    end
  end

  // Every falling edge: all outputs against the model
  always @(negedge clk) begin
    logic [N-1:0] af;
    bit all_empty;
    all_empty = 1'b1;
    for (int k = 0; k < N; k++) begin
      af[k] = (mq[k].size() >= D - 1);
      if (mq[k].size() != 0) all_empty = 1'b0;
    end
    chk("model_valid", 64'(o_valid), 64'(m_valid));
    chk("model_pkt", 64'(o_pkt), 64'(m_pkt));
    chk("model_cell_id", 64'(o_cell_id), 64'(m_id));
    chk("model_almost_full", 64'(o_almost_full), 64'(af));
    chk("model_overflow", 64'(o_overflow), 64'(m_ovf));
    chk("model_idle", 64'(o_idle), 64'(all_empty && !m_valid));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_id;
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_idle", 64'(o_idle), 64'd1);
    chk("reset_pkt", 64'(o_pkt), 64'd0);

    // Push offered on the first edge after reset release must be ignored
    rst = 1'b1; vin = 8'h01; pkt_in[0] = 32'hDEAD0000; ready = 1'b1;
    step();
    vin = '0;
    step(); step();
    chk("no_push_after_release", 64'(o_valid), 64'd0);
    chk("no_push_idle", 64'(o_idle), 64'd1);

    // Single packet on cell 3
    vin = 8'h08; pkt_in[3] = 32'h0000_3333;
    step();
    vin = '0;
    step();
    chk("single_valid", 64'(o_valid), 64'd1);
    chk("single_cell_id", 64'(o_cell_id), 64'd3);
    chk("single_pkt", 64'(o_pkt), 64'h3333);
    step();
    chk("single_idle", 64'(o_idle), 64'd1);

    // Flush resets the pointer, then all cells at once
    flush = 1'b1; step(); flush = 1'b0;
    vin = 8'hFF;
    for (int k = 0; k < N; k++) pkt_in[k] = 32'h100 + k;
    step();
    vin = '0;
    for (int k = 0; k < N; k++) begin
      step();
`ifdef POS_ARB_FIXED_PRIO_EN
      exp_id = k;
`else
      exp_id = (k == 7) ? 0 : k + 1;
`endif
      chk("burst_valid", 64'(o_valid), 64'd1);
      chk("burst_cell_id", 64'(o_cell_id), 64'(exp_id));
    end
    step();
    chk("burst_idle", 64'(o_idle), 64'd1);

    // Stalled output, cell 5 filled to overflow
    ready = 1'b0;
    vin = 8'h20; pkt_in[5] = 32'hA500;
    step();
    vin = '0;
    step();
    chk("stall_head_cell", 64'(o_cell_id), 64'd5);
    for (int k = 1; k <= 5; k++) begin
      vin = 8'h20; pkt_in[5] = 32'hA500 + k;
      step();
      chk("stall_almost_full5", 64'(o_almost_full[5]), 64'(k >= 3));
      chk("stall_overflow5", 64'(o_overflow[5]), 64'(k >= 5));
      chk("stall_pkt_held", 64'(o_pkt), 64'hA500);
      chk("stall_valid_held", 64'(o_valid), 64'd1);
    end

    // Flush with buffered packets and a same-cycle push
    vin = 8'h02; pkt_in[1] = 32'hF1F1; flush = 1'b1;
    step();
    vin = '0; flush = 1'b0;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_idle", 64'(o_idle), 64'd1);
    chk("flush_overflow_kept", 64'(o_overflow), 64'h20);
    chk("flush_almost_full", 64'(o_almost_full), 64'd0);

    // Full FIFO 2 accepts a push when popped in the same cycle
    vin = 8'h04; pkt_in[2] = 32'hC200;
    step();
    vin = '0;
    step();
    for (int k = 1; k <= 4; k++) begin
      vin = 8'h04; pkt_in[2] = 32'hC200 + k;
      step();
    end
    chk("full2_no_overflow", 64'(o_overflow[2]), 64'd0);
    ready = 1'b1; vin = 8'h04; pkt_in[2] = 32'hC205;
    step();
    vin = '0;
    chk("pop_push_overflow2", 64'(o_overflow[2]), 64'd0);
    chk("pop_push_pkt", 64'(o_pkt), 64'hC201);
    chk("pop_push_almost_full2", 64'(o_almost_full[2]), 64'd1);
    repeat (6) step();
    chk("drain_idle", 64'(o_idle), 64'd1);

    // Asynchronous reset in the middle of a stream
    for (int k = 0; k < 6; k++) begin
      vin = 8'(($urandom % 255) + 1);
      for (int j = 0; j < N; j++) pkt_in[j] = $urandom;
      step();
    end
    chk("stream_valid", 64'(o_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(o_valid), 64'd0);
    chk("async_rst_idle", 64'(o_idle), 64'd1);
    chk("async_rst_overflow", 64'(o_overflow), 64'd0);
    @(negedge clk);
    vin = '0;
    rst = 1'b1;
    step();

    // Randomized traffic with varying back-pressure
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int density;
      density = (cyc / 500) % 3;
      vin = '0;
      for (int j = 0; j < N; j++) begin
        vin[j] = ($urandom_range(0, 3) < density + 1);
        pkt_in[j] = $urandom;
      end
      ready = ((cyc / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    vin = '0; flush = 1'b0; ready = 1'b1;
    repeat (40) step();
    chk("final_idle", 64'(o_idle), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
